// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-address controller.
// Purely declarative; no latency.
// No flow control.
package pc_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;
    localparam logic [31:0] PC_STEP              = 32'd4;

    typedef enum logic {
        RUN,
        PEND
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_ERET,
        SRC_EXC
    } src_t;

    typedef struct packed {
        src_t        src;
        logic [31:0] target;
    } redirect_t;

    // Redirects that squash the instruction already fetched (jumps keep their delay slot).
    function automatic logic is_flush_src(input src_t s);
        return (s == SRC_BRANCH) || (s == SRC_ERET) || (s == SRC_EXC);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Picks the winning fetch redirect and its target: exc > eret > branch > pending > jump > seq.
// Combinational, zero latency.
// No flow control; stall handling is left to the caller.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic        exl,
    input  state_t      state,
    input  logic [31:0] epc,
    input  logic [31:0] pend_target,
    input  logic        pend_branch,
    output redirect_t   sel
);

    always_comb begin
        sel.src    = SRC_SEQ;
        sel.target = '0;
        if (exc_req && !exl) begin
            sel.src    = SRC_EXC;
            sel.target = EXC_VECTOR;
        end else if (eret_req && exl) begin
            sel.src    = SRC_ERET;
            sel.target = epc;
        end else if (branch_req) begin
            sel.src    = SRC_BRANCH;
            sel.target = branch_target;
        end else if (state == PEND) begin
            // A held redirect keeps its original kind; new jumps are dropped here.
            sel.src    = pend_branch ? SRC_BRANCH : SRC_JUMP;
            sel.target = pend_target;
        end else if (jump_req) begin
            sel.src    = SRC_JUMP;
            sel.target = jump_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: sequential fetch, jump/branch/exception/eret redirects, EXL tracking.
// Redirect visible on ia one edge after the request; flush follows for one cycle.
// stall holds ia and parks branch/jump redirects in PEND; exc/eret ignore stall.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        eret_req,
    output logic [31:0] ia,
    output logic        flush,
    output logic [31:0] epc,
    output logic        exl,
    output logic        pend
);

    state_t      state, state_d;
    logic [31:0] ia_d, epc_d, pend_target, pend_target_d;
    logic        exl_d, flush_d, pend_branch, pend_branch_d;
    redirect_t   sel;

    pc_redirect_arb #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .jump_req      (jump_req),
        .jump_target   (jump_target),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .exl           (exl),
        .state         (state),
        .epc           (epc),
        .pend_target   (pend_target),
        .pend_branch   (pend_branch),
        .sel           (sel)
    );

    always_comb begin
        state_d       = state;
        ia_d          = ia;
        epc_d         = epc;
        exl_d         = exl;
        flush_d       = 1'b0;
        pend_target_d = pend_target;
        pend_branch_d = pend_branch;
        unique case (sel.src)
            SRC_EXC: begin
                ia_d    = sel.target;
                epc_d   = exc_pc;
                exl_d   = 1'b1;
                state_d = RUN;
                flush_d = 1'b1;
            end
            SRC_ERET: begin
                ia_d    = sel.target;
                exl_d   = 1'b0;
                state_d = RUN;
                flush_d = 1'b1;
            end
            SRC_BRANCH, SRC_JUMP: begin
                if (stall) begin
                    // Flush is withheld until the deferred load actually happens.
                    state_d       = PEND;
                    pend_target_d = sel.target;
                    pend_branch_d = (sel.src == SRC_BRANCH);
                end else begin
                    ia_d    = sel.target;
                    state_d = RUN;
                    flush_d = is_flush_src(sel.src);
                end
            end
            default: begin
                if (!stall) begin
                    ia_d = ia + PC_STEP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            ia          <= RESET_VECTOR;
            epc         <= '0;
            exl         <= 1'b0;
            flush       <= 1'b0;
            pend_target <= '0;
            pend_branch <= 1'b0;
        end else begin
            state       <= state_d;
            ia          <= ia_d;
            epc         <= epc_d;
            exl         <= exl_d;
            flush       <= flush_d;
            pend_target <= pend_target_d;
            pend_branch <= pend_branch_d;
        end
    end

    assign pend = (state == PEND);

endmodule
